// File: rtl/eeg_stream_if.sv
// Valid/ready byte stream carrying processed EEG samples into the UART framer.
// The master drives data/valid; the slave answers with ready.
interface eeg_stream_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/eeg_result_uart_tx.sv
// Buffers EEG samples in a FIFO and sends them as UART 8N1 frames: A5, seq, samples[, checksum].
// The checksum byte is compiled in only when EEG_TX_CHECKSUM_EN is defined.
module eeg_result_uart_tx #(
    parameter int CLKS_PER_BIT      = 868,
    parameter int FIFO_DEPTH        = 16,
    parameter int SAMPLES_PER_FRAME = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    eeg_stream_if.slave                 s,
    output logic                        txd,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int SMP_W = $clog2(SAMPLES_PER_FRAME) + 1;
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(SAMPLES_PER_FRAME - 1);

`ifdef EEG_TX_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEQ, ST_DATA, ST_CSUM} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_SEQ, ST_DATA} state_t;
`endif

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       shift_q, shift_d;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [7:0]       seq_q, seq_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
`ifdef EEG_TX_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic       push, pop, load, last_byte;
    logic [7:0] load_byte, rd_data;

    // Ready depends only on the registered level, so a same-cycle pop never admits a push when full.
    assign s.s_ready = (level_q < LVL_W'(FIFO_DEPTH));
    assign push      = s.s_valid && s.s_ready;
    assign rd_data   = fifo_mem[rd_ptr_q];

`ifdef EEG_TX_CHECKSUM_EN
    assign last_byte = (state_q == ST_CSUM);
`else
    assign last_byte = (state_q == ST_DATA) && (smp_q == SMP_LAST);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        smp_d        = smp_q;
        txd_d        = txd_q;
        frame_done_d = 1'b0;
        seq_d        = frame_done_q ? seq_q + 8'd1 : seq_q;
`ifdef EEG_TX_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        pop          = 1'b0;
        load         = 1'b0;
        load_byte    = 8'h00;

        if (state_q == ST_IDLE) begin
            if (level_q >= LVL_W'(SAMPLES_PER_FRAME)) begin
                state_d   = ST_SYNC;
                load      = 1'b1;
                load_byte = SYNC_BYTE;
            end
        end else begin
            frame_done_d = last_byte && (bit_q == 4'd9) && (cnt_q == CNT_PRE);
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (bit_q != 4'd9) begin
                cnt_d   = '0;
                bit_d   = bit_q + 4'd1;
                txd_d   = shift_q[0];
                shift_d = {1'b1, shift_q[8:1]};
            end else begin
                // End of a stop bit: chain the next byte with no idle gap, or finish the frame.
                case (state_q)
                    ST_SYNC: begin
                        state_d   = ST_SEQ;
                        load      = 1'b1;
                        load_byte = seq_q;
`ifdef EEG_TX_CHECKSUM_EN
                        csum_d    = seq_q;
`endif
                    end
                    ST_SEQ: begin
                        state_d   = ST_DATA;
                        load      = 1'b1;
                        load_byte = rd_data;
                        pop       = 1'b1;
                        smp_d     = '0;
`ifdef EEG_TX_CHECKSUM_EN
                        csum_d    = csum_q + rd_data;
`endif
                    end
                    ST_DATA: begin
                        if (smp_q == SMP_LAST) begin
`ifdef EEG_TX_CHECKSUM_EN
                            state_d   = ST_CSUM;
                            load      = 1'b1;
                            load_byte = csum_q;
`else
                            state_d   = ST_IDLE;
`endif
                        end else begin
                            load      = 1'b1;
                            load_byte = rd_data;
                            pop       = 1'b1;
                            smp_d     = smp_q + SMP_W'(1);
`ifdef EEG_TX_CHECKSUM_EN
                            csum_d    = csum_q + rd_data;
`endif
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        if (load) begin
            txd_d   = 1'b0;
            shift_d = {1'b1, load_byte};
            cnt_d   = '0;
            bit_d   = 4'd0;
        end

        busy_d   = (state_d != ST_IDLE);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= s.s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
            shift_q      <= 9'h1FF;
            smp_q        <= '0;
            seq_q        <= 8'h00;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef EEG_TX_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            smp_q        <= smp_d;
            seq_q        <= seq_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef EEG_TX_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_eeg_result_uart_tx.sv
// Directed bench for eeg_result_uart_tx: decodes txd as 8N1 and compares frames with hand-built expectations.
// Expected frame length follows EEG_TX_CHECKSUM_EN the same way the design does.
module tb_eeg_result_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int SPF   = 4;
`ifdef EEG_TX_CHECKSUM_EN
    localparam int NB = SPF + 3;
`else
    localparam int NB = SPF + 2;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic txd, busy, frame_done;
    logic [$clog2(DEPTH):0] fifo_level;

    eeg_stream_if sif();

    eeg_result_uart_tx #(
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SAMPLES_PER_FRAME(SPF)
    ) dut (
        .clk(clk), .rst(rst), .s(sif), .txd(txd), .busy(busy),
        .frame_done(frame_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: samples each bit at its midpoint, counted from the first low sample of the start bit.
    bit         dec_active = 1'b0;
    int         dec_cnt, dec_start;
    logic [7:0] dec_byte;
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    int         fd_q[$];
    int         stop_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (txd === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
                dec_start  = cyc;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % CPB == CPB / 2) begin
                if (dec_cnt / CPB >= 1 && dec_cnt / CPB <= 8) begin
                    dec_byte[dec_cnt / CPB - 1] = txd;
                end else if (dec_cnt / CPB == 9) begin
                    if (txd !== 1'b1) stop_err++;
                    rx_q.push_back(dec_byte);
                    rx_cyc_q.push_back(dec_start);
                    dec_active = 1'b0;
                end
            end
        end
        if (!rst && frame_done === 1'b1) fd_q.push_back(cyc);
    end

    logic [7:0] exp_seq = 8'h00;

    task automatic push_byte(input logic [7:0] v);
        @(negedge clk);
        sif.s_data  = v;
        sif.s_valid = 1'b1;
        @(posedge clk);
        #1 sif.s_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [8*SPF-1:0] smp);
        for (int i = 0; i < SPF; i++) push_byte(smp[8*i +: 8]);
    endtask

    // Waits for the next frame_done, then checks byte content and the pulse position within the frame.
    task automatic check_frame(input string name, input logic [8*SPF-1:0] smp,
                               output int fd_cyc, output int start_cyc);
        logic [7:0] exp_b[$];
        logic [7:0] cs, got;
        int         n;
        exp_b = {8'hA5, exp_seq};
        cs    = exp_seq;
        for (int i = 0; i < SPF; i++) begin
            exp_b.push_back(smp[8*i +: 8]);
            cs = cs + smp[8*i +: 8];
        end
`ifdef EEG_TX_CHECKSUM_EN
        exp_b.push_back(cs);
`endif
        fd_cyc = 0;
        start_cyc = 0;
        n = 0;
        while (fd_q.size() == 0 && n < 2 * FRAME_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        check_val({name, " frame_done seen"}, fd_q.size() > 0, 1);
        if (fd_q.size() == 0) return;
        fd_cyc = fd_q.pop_front();
        check_val({name, " bytes received"}, rx_q.size() >= NB, 1);
        if (rx_q.size() < NB) return;
        start_cyc = rx_cyc_q[0];
        for (int i = 0; i < NB; i++) begin
            got = rx_q.pop_front();
            void'(rx_cyc_q.pop_front());
            check_val($sformatf("%s byte%0d", name, i), got, exp_b[i]);
        end
        // The pulse occupies the final cycle of the frame's bit time.
        check_val({name, " frame_done offset"}, fd_cyc - start_cyc, FRAME_CYC - 1);
        $display("frame %s: seq=%02h samples=%08h start@%0d done@%0d", name, exp_seq, smp, start_cyc, fd_cyc);
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_c, st_c, prev_fd, n, bad, v, budget, ready_bad;
        bit saw_full, acc;

        rst = 1'b1;
        sif.s_data  = 8'h00;
        sif.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset txd", txd, 1);
        check_val("reset busy", busy, 0);
        check_val("reset frame_done", frame_done, 0);
        check_val("reset fifo_level", fifo_level, 0);
        check_val("reset s_ready", sif.s_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame.
        push_frame(32'h40302010);
        check_frame("basic", 32'h40302010, fd_c, st_c);
        repeat (20) @(negedge clk);
        check_val("basic single pulse", fd_q.size(), 0);
        check_val("basic fifo_level", fifo_level, 0);
        check_val("basic busy", busy, 0);

        // Partial frame: three samples never start a frame.
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 3) bad++;
        end
        check_val("partial idle cycles", bad, 0);
        check_val("partial level", fifo_level, 3);
        push_byte(8'h04);
        check_val("partial 4th busy", busy, 0);
        check_val("partial 4th level", fifo_level, 4);
        @(posedge clk);
        #1;
        check_val("partial sync busy", busy, 1);
        check_val("partial sync txd", txd, 0);
        check_frame("partial", 32'h04030201, fd_c, st_c);

        // Backpressure: 20 values offered back to back.
        v = 0; budget = 0; saw_full = 1'b0; ready_bad = 0;
        while (v < 20 && budget < 2000) begin
            @(negedge clk);
            sif.s_data  = 8'h50 + 8'(v);
            sif.s_valid = 1'b1;
            if (fifo_level == 16 && sif.s_ready === 1'b0) saw_full = 1'b1;
            if (sif.s_ready !== (fifo_level < 16)) ready_bad++;
            acc = sif.s_ready;
            @(posedge clk);
            if (acc) v++;
            budget++;
        end
        @(negedge clk);
        sif.s_valid = 1'b0;
        check_val("bp all pushed", v, 20);
        check_val("bp reached full", saw_full, 1);
        check_val("bp ready vs level", ready_bad, 0);
        prev_fd = 0;
        for (int f = 0; f < 5; f++) begin
            logic [8*SPF-1:0] smp;
            for (int i = 0; i < SPF; i++) smp[8*i +: 8] = 8'h50 + 8'(f * SPF + i);
            check_frame($sformatf("bp%0d", f), smp, fd_c, st_c);
            if (f > 0) check_val($sformatf("bp%0d idle gap", f), st_c - prev_fd, 2);
            prev_fd = fd_c;
        end

        // Reset in the middle of the first data byte's bit 3.
        push_frame(32'h64636261);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("rst frame started", busy, 1);
        repeat (97) @(negedge clk);
        check_val("rst pre txd", txd, 0);
        check_val("rst pre level", fifo_level, 3);
        #2 rst = 1'b1;
        #1;
        check_val("rst async txd", txd, 1);
        check_val("rst async level", fifo_level, 0);
        check_val("rst async busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        rx_cyc_q.delete();
        fd_q.delete();
        exp_seq = 8'h00;
        repeat (5) @(negedge clk);
        check_val("rst idle txd", txd, 1);
        push_frame(32'h74737271);
        check_frame("after_rst", 32'h74737271, fd_c, st_c);

        // Sequence wrap over 257 frames of zero samples.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        rx_cyc_q.delete();
        fd_q.delete();
        exp_seq = 8'h00;
        for (int f = 1; f <= 257; f++) begin
            push_frame('0);
            check_frame($sformatf("wrap%0d", f), '0, fd_c, st_c);
        end

        check_val("stop bits", stop_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eeg_result_uart_tx.md
Name: eeg_result_uart_tx

Overview:
- Return path from the FPGA to the MicroPython host.
- Accepts 8-bit processed EEG samples on a valid/ready stream and buffers them in a small FIFO.
- Packs them into fixed-length frames: sync byte, sequence number, N samples, optional checksum.
- Serializes each frame on a UART 8N1 line read by the host script.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16: sample FIFO entries; power of two, >= SAMPLES_PER_FRAME.
- SAMPLES_PER_FRAME, 4: samples carried in each frame; range 1..FIFO_DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- s_data  input  8  processed EEG sample.
- s_valid  input  1  s_data is valid this cycle.
- s_ready  output  1  FIFO can accept a sample.
- txd  output  1  UART serial output; idle high.
- busy  output  1  a frame is being transmitted (state != IDLE).
- frame_done  output  1  one-cycle pulse at the end of the last stop bit of a frame.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high; also mid-frame):
  - Immediately forces txd=1, busy=0, frame_done=0, fifo_level=0, sequence counter=0, state=IDLE.
  - FIFO contents are discarded. A partial frame is abandoned and is not resumed.
- Input handshake:
  - s_ready = (fifo_level < FIFO_DEPTH), combinational from the registered level.
  - A push occurs on any cycle with s_valid && s_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_level unchanged.
- Frame start: in IDLE, a frame starts when fifo_level >= SAMPLES_PER_FRAME. The FSM moves to SYNC on the next edge.
- Byte serializer:
  - On the clock edge that loads a byte, txd goes 0 (start bit).
  - Then 8 data bits are sent LSB first, then a stop bit of 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles, so one byte occupies 10*CLKS_PER_BIT cycles.
  - Consecutive bytes in a frame are back-to-back: the next start bit begins on the cycle after the previous stop bit ends, with no idle gap.
- FSM states: IDLE -> SYNC -> SEQ -> DATA -> CSUM -> IDLE.
  - SYNC: sends 0xA5.
  - SEQ: sends the sequence counter.
  - DATA: sends SAMPLES_PER_FRAME bytes. Each byte is popped from the FIFO at the moment it is loaded into the shifter.
  - CSUM: sends the checksum byte.
- Checksum: 8-bit sum, mod 256, of the sequence byte and all sample bytes. The sync byte is excluded.
- Sequence counter: increments by 1 when frame_done pulses; wraps 255 -> 0.
- Back-to-back frames:
  - frame_done pulses in the last cycle of the final stop bit, and the state returns to IDLE on that edge.
  - If enough samples are buffered, the next frame starts with one cycle of IDLE between frames.
- Push during transmission is always allowed while not full; popped entries free space immediately.
- Frame timing: frame length is (2 + SAMPLES_PER_FRAME + 1) bytes, or 2 + SAMPLES_PER_FRAME bytes without checksum. Duration is bytes * 10 * CLKS_PER_BIT cycles.

Optional Feature:
- Macro: EEG_TX_CHECKSUM_EN.
- Defined: the CSUM state and checksum byte are present as described; DATA -> CSUM -> IDLE.
- Undefined: no checksum logic or state; DATA -> IDLE after the last sample's stop bit.
- frame_done and sequence-counter timing shift accordingly.

Test Plan:
- Basic frame:
  - Setup: CLKS_PER_BIT=4, SAMPLES_PER_FRAME=4, checksum on.
  - Stimulus: push 0x10,0x20,0x30,0x40.
  - Required: txd decodes A5 00 10 20 30 40 A0.
  - Required: frame_done pulses once, 280 cycles after the first start bit.
  - Required: fifo_level returns to 0.
- Partial frame: push 3 samples only -> txd stays 1, busy stays 0, fifo_level=3 indefinitely. The 4th push starts SYNC on the next edge.
- Full FIFO backpressure:
  - Stimulus: hold s_valid=1 with 20 consecutive values.
  - Required: s_ready drops when fifo_level=16.
  - Required: no sample is lost or duplicated; frames carry values in push order.
- Sequence wrap:
  - Stimulus: send 257 frames of 0x00 samples.
  - Required: frame 256 has seq 0xFF with checksum 0xFF.
  - Required: frame 257 has seq 0x00 with checksum 0x00.
- Reset mid-frame:
  - Stimulus: assert rst during a DATA byte's bit 3.
  - Required: txd=1 and fifo_level=0 immediately, without waiting for a clock.
  - Required: after release and 4 new pushes, the frame starts with seq 0x00.
- Checksum compiled out: EEG_TX_CHECKSUM_EN undefined, push 0xFF x4 -> txd decodes A5 00 FF FF FF FF; frame_done at 240 cycles.
